// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM pipeline control slice.
package arm_pipe_pkg;

    localparam int REG_IDX_W = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_e;

    // Saturation value of a w-bit counter; wraps to all-ones correctly for w up to 32.
    function automatic int unsigned cnt_sat(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// RAW hazard detection between the ID sources and the EXE/MEM destinations.
// Purely combinational; with forwarding only a load in EXE can cause a stall.
module hazard_detect
    import arm_pipe_pkg::*;
(
    input  logic                 forward_en_i,
    input  logic [REG_IDX_W-1:0] id_src1_i,
    input  logic [REG_IDX_W-1:0] id_src2_i,
    input  logic                 id_two_src_i,
    input  logic [REG_IDX_W-1:0] exe_dest_i,
    input  logic                 exe_wb_en_i,
    input  logic                 exe_mem_r_en_i,
    input  logic [REG_IDX_W-1:0] mem_dest_i,
    input  logic                 mem_wb_en_i,
    output logic                 raw_o
);

    logic e1, e2, m1, m2;

    assign e1 = exe_wb_en_i & (exe_dest_i == id_src1_i);
    assign e2 = exe_wb_en_i & id_two_src_i & (exe_dest_i == id_src2_i);
    assign m1 = mem_wb_en_i & (mem_dest_i == id_src1_i);
    assign m2 = mem_wb_en_i & id_two_src_i & (mem_dest_i == id_src2_i);

    assign raw_o = forward_en_i ? (exe_mem_r_en_i & (e1 | e2)) : (e1 | e2 | m1 | m2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: data-hazard bubbles, branch flushes, whole-pipe freeze on SRAM wait.
// Control outputs are Mealy from state and inputs; counters and timeout flag are registered.
module pipeline_ctrl
    import arm_pipe_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 forward_en,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_wb_en,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 cnt_clr,
    output logic                 hazard_out,
    output logic                 freeze_if,
    output logic                 flush_if_id,
    output logic                 flush_id_exe,
    output logic                 freeze_pipe,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic [CNT_W-1:0]     memwait_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(cnt_sat(CNT_W));

    pipe_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d, memwait_q, memwait_d;
    logic              raw, hazard_c, flush_c, freeze_c;

    hazard_detect u_hazard_detect (
        .forward_en_i   (forward_en),
        .id_src1_i      (id_src1),
        .id_src2_i      (id_src2),
        .id_two_src_i   (id_two_src),
        .exe_dest_i     (exe_dest),
        .exe_wb_en_i    (exe_wb_en),
        .exe_mem_r_en_i (exe_mem_r_en),
        .mem_dest_i     (mem_dest),
        .mem_wb_en_i    (mem_wb_en),
        .raw_o          (raw)
    );

    // Memory wait dominates; the ready cycle out of MEM_WAIT behaves like RUN.
    always_comb begin
        state_d  = state_q;
        hazard_c = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        if ((state_q == RUN) && mem_req && !mem_ready) begin
            freeze_c = 1'b1;
            state_d  = MEM_WAIT;
        end else if ((state_q == MEM_WAIT) && !mem_ready) begin
            freeze_c = 1'b1;
        end else begin
            state_d = RUN;
            if (branch_taken) begin
                flush_c = 1'b1;
            end else if (raw) begin
                hazard_c = 1'b1;
            end
        end
    end

    // Wait counter spans every frozen cycle, the entry cycle included.
    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (freeze_c) begin
            if (wait_q == WAIT_LAST) begin
                timeout_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
        stall_d   = (hazard_c && stall_q   != CNT_MAX) ? stall_q   + 1'b1 : stall_q;
        flush_d   = (flush_c  && flush_q   != CNT_MAX) ? flush_q   + 1'b1 : flush_q;
        memwait_d = (freeze_c && memwait_q != CNT_MAX) ? memwait_q + 1'b1 : memwait_q;
        if (cnt_clr) begin
            timeout_d = 1'b0;
            stall_d   = '0;
            flush_d   = '0;
            memwait_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
            memwait_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            memwait_q <= memwait_d;
        end
    end

    assign hazard_out   = rst & hazard_c;
    assign freeze_if    = rst & hazard_c;
    assign flush_if_id  = rst & flush_c;
    assign flush_id_exe = rst & flush_c;
    assign freeze_pipe  = rst & freeze_c;
    assign mem_timeout  = timeout_q;
    assign stall_cnt    = stall_q;
    assign flush_cnt    = flush_q;
    assign memwait_cnt  = memwait_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic against a cycle model.
module tb_pipeline_ctrl;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int SAT         = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic forward_en = 0, id_two_src = 0, exe_wb_en = 0, exe_mem_r_en = 0, mem_wb_en = 0;
    logic branch_taken = 0, mem_req = 0, mem_ready = 0, cnt_clr = 0;
    logic [3:0] id_src1 = 0, id_src2 = 0, exe_dest = 0, mem_dest = 0;
    logic hazard_out, freeze_if, flush_if_id, flush_id_exe, freeze_pipe, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit m_wait;
    int m_wcnt, m_stall, m_flush, m_mw;
    bit m_to;
    bit e_haz, e_flush, e_fp;

    pipeline_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .forward_en(forward_en),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .hazard_out(hazard_out), .freeze_if(freeze_if), .flush_if_id(flush_if_id),
        .flush_id_exe(flush_id_exe), .freeze_pipe(freeze_pipe), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .memwait_cnt(memwait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit model_raw();
        bit e1, e2, m1, m2;
        e1 = exe_wb_en && (exe_dest == id_src1);
        e2 = exe_wb_en && id_two_src && (exe_dest == id_src2);
        m1 = mem_wb_en && (mem_dest == id_src1);
        m2 = mem_wb_en && id_two_src && (mem_dest == id_src2);
        if (forward_en) return exe_mem_r_en && (e1 || e2);
        return e1 || e2 || m1 || m2;
    endfunction

    function automatic int sat_add(input int v, input bit inc);
        return (inc && v < SAT) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_wait = 0; m_wcnt = 0; m_to = 0; m_stall = 0; m_flush = 0; m_mw = 0;
    endtask

    task automatic model_outputs();
        e_haz = 0; e_flush = 0; e_fp = 0;
        if (!mem_ready && (m_wait || mem_req)) e_fp = 1;
        else if (branch_taken)                 e_flush = 1;
        else if (model_raw())                  e_haz = 1;
    endtask

    task automatic model_clock();
        if (e_fp) begin
            m_wcnt++;
            if (m_wcnt == MEM_TIMEOUT) begin m_to = 1; m_wcnt = 0; end
        end else begin
            m_wcnt = 0;
        end
        m_wait  = e_fp;
        m_stall = sat_add(m_stall, e_haz);
        m_flush = sat_add(m_flush, e_flush);
        m_mw    = sat_add(m_mw, e_fp);
        if (cnt_clr) begin m_stall = 0; m_flush = 0; m_mw = 0; m_to = 0; end
    endtask

    // Entered just after a rising edge with inputs applied; returns just after the next one.
    task automatic step();
        #2;
        model_outputs();
        chk("hazard_out",   hazard_out,   e_haz);
        chk("freeze_if",    freeze_if,    e_haz);
        chk("flush_if_id",  flush_if_id,  e_flush);
        chk("flush_id_exe", flush_id_exe, e_flush);
        chk("freeze_pipe",  freeze_pipe,  e_fp);
        chk("mem_timeout",  mem_timeout,  m_to);
        chk("stall_cnt",    stall_cnt,    m_stall);
        chk("flush_cnt",    flush_cnt,    m_flush);
        chk("memwait_cnt",  memwait_cnt,  m_mw);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic expect_out(input string tag, input bit haz, input bit fl, input bit fp);
        #1;
        chk({tag, "_haz"}, hazard_out, haz);
        chk({tag, "_fif"}, freeze_if, haz);
        chk({tag, "_flush"}, flush_if_id & flush_id_exe, fl);
        chk({tag, "_fp"}, freeze_pipe, fp);
    endtask

    task automatic idle_inputs();
        forward_en = 0; id_two_src = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
        id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
    endtask

    initial begin
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fp", freeze_pipe, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_to", mem_timeout, 0);
        rst = 1'b1;

        // plain RAW hazard without forwarding
        exe_wb_en = 1; exe_dest = 3; id_src1 = 3;
        expect_out("raw", 1, 0, 0);
        step();
        exe_wb_en = 0;
        step();
        chk("raw_stall_cnt", stall_cnt, 1);

        // load-use with forwarding on the second source
        forward_en = 1; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 5;
        id_two_src = 1; id_src2 = 5; id_src1 = 0;
        expect_out("ldu", 1, 0, 0);
        step();
        exe_mem_r_en = 0;
        expect_out("fwd", 0, 0, 0);
        step();

        // branch beats a data hazard
        forward_en = 0; exe_wb_en = 1; exe_dest = 3; id_src1 = 3; branch_taken = 1;
        expect_out("br", 0, 1, 0);
        step();
        idle_inputs();
        step();
        chk("br_flush_cnt", flush_cnt, 1);

        // memory wait with a pending branch
        branch_taken = 1; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            expect_out("mw", 0, 0, 1);
            step();
        end
        mem_ready = 1;
        expect_out("mw_rdy", 0, 1, 0);
        step();
        idle_inputs();
        step();
        chk("mw_memwait_cnt", memwait_cnt, 4);
        chk("mw_flush_cnt", flush_cnt, 2);

        // timeout flag after MEM_TIMEOUT frozen cycles, freeze persists, clear drops flag
        cnt_clr = 1; step(); cnt_clr = 0;
        mem_req = 1; mem_ready = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("to_flag", mem_timeout, (k >= MEM_TIMEOUT) ? 1 : 0);
        end
        expect_out("to_still", 0, 0, 1);
        cnt_clr = 1; step(); cnt_clr = 0;
        chk("to_clr", mem_timeout, 0);
        mem_ready = 1; step();

        // asynchronous reset in the middle of a memory wait
        idle_inputs();
        mem_req = 1; mem_ready = 0;
        step(); step(); step();
        #2;
        rst = 1'b0;
        #1;
        chk("arst_fp", freeze_pipe, 0);
        chk("arst_memwait", memwait_cnt, 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        mem_req = 0; mem_ready = 0;
        expect_out("arst_run", 0, 0, 0);
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int slow;
            slow = (c / 200) % 2;
            forward_en   = $urandom_range(0, 1);
            id_src1      = 4'($urandom_range(0, 3)) | ((c % 97 == 0) ? 4'hF : 4'h0);
            id_src2      = 4'($urandom_range(0, 3));
            id_two_src   = $urandom_range(0, 1);
            exe_dest     = 4'($urandom_range(0, 3)) | ((c % 97 == 0) ? 4'hF : 4'h0);
            exe_wb_en    = ($urandom_range(0, 3) != 0);
            exe_mem_r_en = $urandom_range(0, 1);
            mem_dest     = 4'($urandom_range(0, 3));
            mem_wb_en    = $urandom_range(0, 1);
            branch_taken = ($urandom_range(0, 4) == 0);
            mem_req      = $urandom_range(0, 1);
            mem_ready    = slow ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) > 3);
            cnt_clr      = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Detects RAW hazards between the ID-stage sources and the EXE/MEM destinations, and drives the ID-stage hazard input.
- Sequences branch flushes and freezes the whole pipeline while the data-memory (SRAM) access is not ready.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of each performance counter
MEM_TIMEOUT, 64, maximum consecutive MEM_WAIT cycles before mem_timeout is set

Ports:
clk  input  1  pipeline clock, rising edge
rst  input  1  asynchronous, active-low reset
forward_en  input  1  1 = forwarding unit active; only load-use hazards stall
id_src1  input  4  ID-stage Rn index
id_src2  input  4  ID-stage second-read index (Rm or Rd for STR)
id_two_src  input  1  ID instruction reads id_src2
exe_dest  input  4  EXE-stage destination register
exe_wb_en  input  1  EXE-stage writeback enable
exe_mem_r_en  input  1  EXE-stage instruction is a load
mem_dest  input  4  MEM-stage destination register
mem_wb_en  input  1  MEM-stage writeback enable
branch_taken  input  1  EXE-stage branch taken (B signal after condition check)
mem_req  input  1  MEM stage performs a read or write this cycle
mem_ready  input  1  SRAM access completes this cycle
cnt_clr  input  1  synchronous clear of counters and mem_timeout
hazard_out  output  1  to ID HazardIn: zero control signals, i.e. insert a bubble
freeze_if  output  1  hold PC and the IF/ID register
flush_if_id  output  1  clear the IF/ID register
flush_id_exe  output  1  clear the ID/EXE register
freeze_pipe  output  1  hold every pipeline register and the PC
mem_timeout  output  1  sticky: a MEM_WAIT lasted MEM_TIMEOUT cycles
stall_cnt  output  CNT_W  count of data-hazard bubble cycles
flush_cnt  output  CNT_W  count of taken-branch flushes
memwait_cnt  output  CNT_W  count of freeze_pipe cycles

Behaviour:
- Outputs hazard_out, freeze_if, flush_*, freeze_pipe are combinational (Mealy) from state and inputs. Counters, state and mem_timeout are registered.
- Reset (asynchronous, rst=0): state=RUN; all counters 0; mem_timeout=0; wait counter 0. All combinational outputs read 0 while rst=0, including mid-MEM_WAIT.
- Raw hazard terms:
  - e1 = exe_wb_en & (exe_dest==id_src1)
  - e2 = exe_wb_en & id_two_src & (exe_dest==id_src2)
  - m1 and m2 are the same terms using mem_dest and mem_wb_en.
- Data hazard:
  - forward_en=0: raw = e1|e2|m1|m2.
  - forward_en=1: raw = exe_mem_r_en & (e1|e2).
- States:
  - RUN:
    - If mem_req & !mem_ready: freeze_pipe=1, all other outputs 0, next state MEM_WAIT.
    - Else if branch_taken: flush_if_id=1, flush_id_exe=1, hazard_out=0, freeze_if=0; stay in RUN.
    - Else if raw: hazard_out=1, freeze_if=1; stay in RUN.
    - Priority is therefore memory wait > branch > data hazard.
  - MEM_WAIT:
    - freeze_pipe = !mem_ready. hazard_out, freeze_if and flush_* are forced 0.
    - mem_ready=1 returns to RUN. In that same cycle freeze_pipe=0 and the branch and hazard rules of RUN apply.
    - A wait counter increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT, mem_timeout is set, the wait counter clears and the state stays in MEM_WAIT.
    - The block never self-releases the freeze; only mem_ready ends it.
- Counters:
  - stall_cnt +1 per cycle with hazard_out=1.
  - flush_cnt +1 per cycle with flush_if_id=1.
  - memwait_cnt +1 per cycle with freeze_pipe=1.
  - All counters saturate at 2^CNT_W-1; there is no wrap.
  - cnt_clr=1 zeroes the counters and mem_timeout on the next edge and takes priority over increment in that cycle.
- A load-use stall lasts exactly one cycle. The bubble moves the load to MEM, where forward_en=1 no longer matches. No extra state is used.
- A register index of 15 is compared like any other index; no special case.

Decomposition:
- Package arm_pipe_pkg holds:
  - REG_IDX_W=4
  - state encoding: RUN=1'b0, MEM_WAIT=1'b1
  - counter saturation constant
- Sub-module hazard_detect (combinational) computes raw from the src/dest/enable inputs and forward_en. It is reused by the forwarding-unit bench.

Test Plan:
- forward_en=0, id_src1=3, exe_dest=3, exe_wb_en=1 -> hazard_out=1, freeze_if=1 for 1 cycle; stall_cnt=1.
- forward_en=1, exe_mem_r_en=1, exe_dest=5, id_two_src=1, id_src2=5 -> 1-cycle bubble. The same pattern with exe_mem_r_en=0 -> hazard_out=0.
- branch_taken=1 together with a raw hazard -> flush_if_id=flush_id_exe=1, hazard_out=0; flush_cnt=1.
- mem_req=1, mem_ready=0 for 4 cycles, then 1, while a branch is pending -> freeze_pipe=1 for 4 cycles and memwait_cnt=4; the flush is asserted in the ready cycle.
- MEM_TIMEOUT=8, mem_ready held 0 for 10 cycles -> mem_timeout=1 after cycle 8, freeze_pipe still 1; cnt_clr clears the flag.
- rst=0 asserted mid-MEM_WAIT -> all outputs 0 immediately; after release the state is RUN and counters are 0.
